// File: rtl/reg_file.sv
// Architectural register file with per-register busy flag and ROB rename tag.
// Optional same-cycle commit-to-lookup bypass: define REG_COMMIT_BYPASS_EN.
module reg_file #(
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [4:0]           reg_rd,
  input  logic [31:0]          reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [4:0]           rs1_pos,
  input  logic [4:0]           rs2_pos,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [31:0]          rs1_val,
  output logic [31:0]          rs2_val,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [31:0]          val_q [32];
  logic [31:0]          val_d [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic [ROB_POS_W-1:0] tag_q [32];
  logic [ROB_POS_W-1:0] tag_d [32];

  logic commit_en;
  logic issue_en;

  assign commit_en = reg_write && (reg_rd != 5'd0);
  assign issue_en  = issue && (issue_rd != 5'd0) && !rollback;

  // Issue is applied after commit so it wins the busy/tag fields on a same-rd collision.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (commit_en) begin
        val_d[reg_rd] = reg_val;
        if (busy_q[reg_rd] && (tag_q[reg_rd] == commit_rob_pos)) begin
          busy_d[reg_rd] = 1'b0;
        end
      end
      if (rollback) begin
        busy_d = '0;
      end else if (issue_en) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // x0 is never written or marked busy, so its stored state already reads as zero.
  always_comb begin
    rs1_busy    = busy_q[rs1_pos];
    rs1_val     = val_q[rs1_pos];
    rs1_rob_pos = tag_q[rs1_pos];
    rs2_busy    = busy_q[rs2_pos];
    rs2_val     = val_q[rs2_pos];
    rs2_rob_pos = tag_q[rs2_pos];
`ifdef REG_COMMIT_BYPASS_EN
    if (rdy && !rst && commit_en && (reg_rd == rs1_pos) &&
        busy_q[rs1_pos] && (tag_q[rs1_pos] == commit_rob_pos)) begin
      rs1_busy = 1'b0;
      rs1_val  = reg_val;
    end
    if (rdy && !rst && commit_en && (reg_rd == rs2_pos) &&
        busy_q[rs2_pos] && (tag_q[rs2_pos] == commit_rob_pos)) begin
      rs2_busy = 1'b0;
      rs2_val  = reg_val;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expected values are hand-computed.
module tb_reg_file;

  localparam int ROB_POS_W = 4;

  logic                 clk = 1'b0;
  logic                 rst, rdy, rollback, issue, reg_write;
  logic [4:0]           issue_rd, reg_rd, rs1_pos, rs2_pos;
  logic [ROB_POS_W-1:0] issue_rob_pos, commit_rob_pos;
  logic [31:0]          reg_val;
  logic                 rs1_busy, rs2_busy;
  logic [31:0]          rs1_val, rs2_val;
  logic [ROB_POS_W-1:0] rs1_rob_pos, rs2_rob_pos;

  int checks = 0;
  int errors = 0;

  reg_file #(.ROB_POS_W(ROB_POS_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs2_pos(rs2_pos),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Advance one edge, then settle inputs 1ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iss, input logic [4:0] ird, input logic [3:0] itag,
                               input logic wr, input logic [4:0] wrd, input logic [3:0] wtag,
                               input logic [31:0] wval, input logic rb);
    issue          = iss;
    issue_rd       = ird;
    issue_rob_pos  = itag;
    reg_write      = wr;
    reg_rd         = wrd;
    commit_rob_pos = wtag;
    reg_val        = wval;
    rollback       = rb;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic lookup(input logic [4:0] a, input logic [4:0] b);
    rs1_pos = a;
    rs2_pos = b;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    lookup(5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    lookup(5'd5, 5'd0);
    checkOutput("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    checkOutput("rst_rs2_busy", 32'(rs2_busy), 32'd0);
    checkOutput("rst_rs1_val", rs1_val, 32'h0);
    checkOutput("rst_rs2_val", rs2_val, 32'h0);
    checkOutput("rst_rs1_tag", 32'(rs1_rob_pos), 32'd0);

    // Issue rd3 tag7, then commit it
    applyStimulus(1'b1, 5'd3, 4'd7, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    lookup(5'd3, 5'd0);
    checkOutput("issue_same_cycle_busy", 32'(rs1_busy), 32'd0);
    tick();
    idle();
    lookup(5'd3, 5'd0);
    checkOutput("iss3_busy", 32'(rs1_busy), 32'd1);
    checkOutput("iss3_tag", 32'(rs1_rob_pos), 32'd7);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd3, 4'd7, 32'hDEADBEEF, 1'b0);
    lookup(5'd3, 5'd3);
`ifdef REG_COMMIT_BYPASS_EN
    checkOutput("bypass_busy", 32'(rs1_busy), 32'd0);
    checkOutput("bypass_val", rs1_val, 32'hDEADBEEF);
    checkOutput("bypass_rs2_val", rs2_val, 32'hDEADBEEF);
`else
    checkOutput("commit_cycle_busy", 32'(rs1_busy), 32'd1);
    checkOutput("commit_cycle_tag", 32'(rs1_rob_pos), 32'd7);
    checkOutput("commit_cycle_val", rs1_val, 32'h0);
`endif
    tick();
    idle();
    lookup(5'd3, 5'd0);
    checkOutput("cmt3_busy", 32'(rs1_busy), 32'd0);
    checkOutput("cmt3_val", rs1_val, 32'hDEADBEEF);

    // Stale commit: younger producer keeps busy
    applyStimulus(1'b1, 5'd4, 4'd2, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd4, 4'd5, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd4, 4'd2, 32'h11, 1'b0);
    lookup(5'd0, 5'd4);
    checkOutput("stale_cycle_busy", 32'(rs2_busy), 32'd1);
    tick();
    idle();
    lookup(5'd4, 5'd0);
    checkOutput("stale_val", rs1_val, 32'h11);
    checkOutput("stale_busy", 32'(rs1_busy), 32'd1);
    checkOutput("stale_tag", 32'(rs1_rob_pos), 32'd5);

    // Issue and commit to the same rd
    applyStimulus(1'b1, 5'd6, 4'd9, 1'b1, 5'd6, 4'd1, 32'h22, 1'b0);
    tick();
    idle();
    lookup(5'd0, 5'd6);
    checkOutput("collide_busy", 32'(rs2_busy), 32'd1);
    checkOutput("collide_tag", 32'(rs2_rob_pos), 32'd9);
    checkOutput("collide_val", rs2_val, 32'h22);

    // Rollback with concurrent commit and issue
    applyStimulus(1'b1, 5'd8, 4'd1, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 4'd2, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd11, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd10, 4'd4, 1'b1, 5'd8, 4'd1, 32'h33, 1'b1);
    tick();
    idle();
    lookup(5'd8, 5'd9);
    checkOutput("rb_r8_busy", 32'(rs1_busy), 32'd0);
    checkOutput("rb_r8_val", rs1_val, 32'h33);
    checkOutput("rb_r9_busy", 32'(rs2_busy), 32'd0);
    lookup(5'd10, 5'd11);
    checkOutput("rb_r10_busy", 32'(rs1_busy), 32'd0);
    checkOutput("rb_r11_busy", 32'(rs2_busy), 32'd0);
    lookup(5'd6, 5'd4);
    checkOutput("rb_r6_busy", 32'(rs1_busy), 32'd0);
    checkOutput("rb_r6_val", rs1_val, 32'h22);
    checkOutput("rb_r4_val", rs2_val, 32'h11);

    // x0 ignores issue and commit
    applyStimulus(1'b1, 5'd0, 4'd5, 1'b1, 5'd0, 4'd5, 32'hFFFFFFFF, 1'b0);
    tick();
    idle();
    lookup(5'd0, 5'd0);
    checkOutput("x0_busy", 32'(rs1_busy), 32'd0);
    checkOutput("x0_val", rs1_val, 32'h0);

    // Commit to a non-busy register writes value only
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 4'd0, 32'h99, 1'b0);
    tick();
    idle();
    lookup(5'd5, 5'd0);
    checkOutput("nb_commit_val", rs1_val, 32'h99);
    checkOutput("nb_commit_busy", 32'(rs1_busy), 32'd0);

    // rdy low freezes state
    rdy = 1'b0;
    applyStimulus(1'b1, 5'd12, 4'd3, 1'b1, 5'd3, 4'd0, 32'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lookup(5'd12, 5'd3);
      checkOutput($sformatf("hold_r12_busy_%0d", i), 32'(rs1_busy), 32'd0);
      checkOutput($sformatf("hold_r3_val_%0d", i), rs2_val, 32'hDEADBEEF);
    end
    rdy = 1'b1;
    idle();

    // Reset mid-operation
    applyStimulus(1'b1, 5'd13, 4'd6, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    tick();
    idle();
    lookup(5'd13, 5'd0);
    checkOutput("pre_rst_r13_busy", 32'(rs1_busy), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 5'd14, 4'd2, 1'b1, 5'd3, 4'd0, 32'h77, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    lookup(5'd13, 5'd3);
    checkOutput("mid_rst_r13_busy", 32'(rs1_busy), 32'd0);
    checkOutput("mid_rst_r13_tag", 32'(rs1_rob_pos), 32'd0);
    checkOutput("mid_rst_r3_val", rs2_val, 32'h0);
    lookup(5'd14, 5'd4);
    checkOutput("mid_rst_r14_busy", 32'(rs1_busy), 32'd0);
    checkOutput("mid_rst_r4_val", rs2_val, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
